mycpu_muldiv_ctrl: RTL and testbench
====================================

Name: mycpu_muldiv_ctrl

Overview:
Sequencer for the HI/LO multiply/divide resource in the EX stage of the myCPU pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the decoded instruction stream.
- Runs a fixed-latency multiply or a 32-iteration restoring divide, then commits HI/LO.
- Raises a pipeline stall while a later HI/LO consumer or producer would collide with an in-flight operation.
- Supports flush from the exception/branch logic.

Parameters:
MUL_LAT, 2, cycles in MUL state (1..4); product registered, committed at end of last MUL cycle

Ports:
clk  in  1  clock
rst  in  1  reset
op_valid  in  1  EX holds a HI/LO-writing instruction this cycle
op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others ignored
src_a  in  32  rs contents (dividend/multiplicand; MTHI/MTLO data)
src_b  in  32  rt contents (divisor/multiplier)
mf_req  in  1  EX holds MFHI/MFLO this cycle
flush  in  1  abort in-flight op and drop op_valid this cycle
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  state != IDLE
stall_o  out  1  freeze IF/ID/EX this cycle
div_by_zero  out  1  one-cycle pulse: DIV/DIVU accepted with src_b == 0

Behaviour:
- One clock domain. Reset is synchronous, active-high (rst sampled on rising clk).
- Reset values: hi=0, lo=0, state=IDLE, busy=0, div_by_zero=0, iteration count=0. rst overrides flush and op_valid; reset mid-op discards it.
- States: IDLE, MUL, DIV, FIX.
- Accept: only in IDLE, when op_valid=1, flush=0 and op is valid. The accept cycle is T. Any op_valid while busy=1 is not accepted and is stalled.
- stall_o = busy & (op_valid | mf_req). The accepting instruction itself never stalls, since busy=0 at T.
- MTHI/MTLO:
  - Written at end of T (hi or lo = src_a). No state change, busy stays 0.
  - The new value is visible at T+1.
- MULT/MULTU:
  - 64-bit product of src_a, src_b, signed or unsigned, registered at T. IDLE→MUL.
  - busy = 1 for cycles T+1..T+MUL_LAT.
  - {hi,lo} = product written at end of T+MUL_LAT. →IDLE.
- DIV/DIVU:
  - At T, latch the operand magnitudes (abs for DIV; raw for DIVU), the quotient sign (sa^sb) and the remainder sign (sa), and clear the iteration count. IDLE→DIV.
  - DIV state: one restoring step per cycle, 32 cycles (T+1..T+32). Count 0..31; at count==31 →FIX.
  - FIX (T+33): negate quotient/remainder per latched signs; lo=quotient, hi=remainder. →IDLE. busy high T+1..T+33.
  - Signed results follow MIPS truncation: quotient rounds toward zero, remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF (DIV): lo=0x80000000, hi=0. No trap.
- Divide by zero: detected at T.
  - div_by_zero pulses during T+1.
  - No state change, hi/lo unchanged, busy stays 0.
- Flush:
  - In IDLE: op_valid is ignored that cycle.
  - In MUL/DIV/FIX: →IDLE next cycle, hi/lo not written, stall_o forced 0 in the flush cycle.
- mf_req while IDLE: no stall; consumer reads hi/lo directly. mf_req in the cycle HI/LO is committed still stalls, because busy=1.

Optional Feature:
MYCPU_DIV_EARLY_OUT_EN
- Defined: at accept, if |divisor| > |dividend| (compared as magnitudes), skip DIV and go directly to FIX with quotient=0, remainder=dividend magnitude. HI/LO are committed at end of T+1, busy only during T+1.
- Not defined: every nonzero divide takes the full 33 busy cycles.

Test Plan:
- MULT src_a=0xFFFFFFFD, src_b=5, MUL_LAT=2 → busy during T+1..T+2; at T+3 hi=0xFFFFFFFF, lo=0xFFFFFFF1. MULTU same operands → hi=0x00000004, lo=0xFFFFFFF1.
- DIVU 100/7 → busy for 33 cycles; at T+34 lo=14, hi=2. DIV 0xFFFFFFF9/2 (−7/2) → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV issued, then MFLO presented at T+1 → stall_o=1 for T+1..T+33, 0 at T+34 with lo valid. A back-to-back MULT at T+1 likewise stalls, then is accepted at T+34.
- MTHI 0x12345678 in IDLE → hi=0x12345678 at T+1, busy never set. DIVU x/0 → div_by_zero pulse at T+1, hi/lo unchanged.
- DIV started, flush at T+10 → state IDLE at T+11, hi/lo keep pre-DIV values, no stall. A repeat with rst at T+10 instead → all outputs at reset values at T+11.
- With MYCPU_DIV_EARLY_OUT_EN, DIVU 3/10 → busy only at T+1; lo=0, hi=3 at T+2. Without the macro → busy 33 cycles, same result.

Source files
------------

// File: rtl/mycpu_muldiv_ctrl.sv
// HI/LO multiply/divide sequencer for the myCPU EX stage: fixed-latency multiply,
// 32-step restoring divide, MTHI/MTLO. Optional divide early-out: MYCPU_DIV_EARLY_OUT_EN.
module mycpu_muldiv_ctrl #(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        mf_req,
    input  logic        flush,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_o,
    output logic        div_by_zero,
    output logic [1:0]  state_dbg
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIX  = 2'd3
    } state_e;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);

    state_e      state_q, state_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    logic [31:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic        q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        dbz_q, dbz_d;

    logic        mult_signed, div_signed, early_out, rem_ge;
    logic [63:0] ext_a, ext_b;
    logic [31:0] mag_a, mag_b, rem_sub;
    logic [32:0] rem_sh;

    assign mult_signed = (op == OP_MULT);
    assign div_signed  = (op == OP_DIV);
    assign ext_a = {(mult_signed ? {32{src_a[31]}} : 32'h0), src_a};
    assign ext_b = {(mult_signed ? {32{src_b[31]}} : 32'h0), src_b};
    assign mag_a = (div_signed && src_a[31]) ? -src_a : src_a;
    assign mag_b = (div_signed && src_b[31]) ? -src_b : src_b;

`ifdef MYCPU_DIV_EARLY_OUT_EN
    assign early_out = (mag_b > mag_a);
`else
    assign early_out = 1'b0;
`endif

    // Restoring step: the remainder always stays below the divisor, so the
    // subtraction result fits in 32 bits whenever it is taken.
    assign rem_sh  = {rem_q, quo_q[31]};
    assign rem_ge  = (rem_sh >= {1'b0, dvsr_q});
    assign rem_sub = rem_sh[31:0] - dvsr_q;

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        cnt_d   = cnt_q;
        dbz_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (op_valid && !flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = ext_a * ext_b;
                            cnt_d   = 5'd0;
                            state_d = S_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (src_b == 32'd0) begin
                                dbz_d = 1'b1;
                            end else begin
                                dvsr_d  = mag_b;
                                q_neg_d = div_signed & (src_a[31] ^ src_b[31]);
                                r_neg_d = div_signed & src_a[31];
                                cnt_d   = 5'd0;
                                if (early_out) begin
                                    quo_d   = 32'd0;
                                    rem_d   = mag_a;
                                    state_d = S_FIX;
                                end else begin
                                    quo_d   = mag_a;
                                    rem_d   = 32'd0;
                                    state_d = S_DIV;
                                end
                            end
                        end
                        OP_MTHI: hi_d = src_a;
                        OP_MTLO: lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (cnt_q == MUL_LAST) begin
                    hi_d    = prod_q[63:32];
                    lo_d    = prod_q[31:0];
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    quo_d = {quo_q[30:0], rem_ge};
                    rem_d = rem_ge ? rem_sub : rem_sh[31:0];
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (!flush) begin
                    lo_d = q_neg_q ? -quo_q : quo_q;
                    hi_d = r_neg_q ? -rem_q : rem_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            prod_q  <= 64'd0;
            quo_q   <= 32'd0;
            rem_q   <= 32'd0;
            dvsr_q  <= 32'd0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= 5'd0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvsr_q  <= dvsr_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            cnt_q   <= cnt_d;
            dbz_q   <= dbz_d;
        end
    end

    assign hi          = hi_q;
    assign lo          = lo_q;
    assign busy        = (state_q != S_IDLE);
    assign stall_o     = busy & ~flush & (op_valid | mf_req);
    assign div_by_zero = dbz_q;
    assign state_dbg   = state_q;
endmodule

// File: tb/tb_mycpu_muldiv_ctrl.sv
// Directed bench for mycpu_muldiv_ctrl: inputs driven and outputs sampled on the falling edge.
module tb_mycpu_muldiv_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = 32'd0;
    logic [31:0] src_b = 32'd0;
    logic        mf_req = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] hi, lo;
    logic        busy, stall_o, div_by_zero;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_pass = 0;
    int cyc;

    localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010;
    localparam logic [2:0] OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101;

    mycpu_muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op), .src_a(src_a), .src_b(src_b),
        .mf_req(mf_req), .flush(flush), .hi(hi), .lo(lo), .busy(busy), .stall_o(stall_o),
        .div_by_zero(div_by_zero), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present an op for one cycle (T); returns settled in T+1 with op_valid low.
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
    endtask

    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 200) begin
            cycles++;
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; op_valid = 1'b1; op = OP_MTHI; src_a = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        #1;
        n_checks++; if (hi !== 32'd0) $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL reset_dbz: got %b expected 0", div_by_zero); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state_dbg); else n_pass++;
    endtask

    task automatic test_mul();
        @(negedge clk);
        op_valid = 1'b1; op = OP_MULT; src_a = 32'hFFFF_FFFD; src_b = 32'd5;
        #1;
        n_checks++; if (stall_o !== 1'b0) $display("FAIL mult_accept_stall: got %b expected 0", stall_o); else n_pass++;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        wait_idle(cyc);
        n_checks++; if (cyc !== 2) $display("FAIL mult_busy_cycles: got %0d expected %0d", cyc, 2); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mult_hi: got %h expected %h", hi, 32'hFFFF_FFFF); else n_pass++;
        n_checks++; if (lo !== 32'hFFFF_FFF1) $display("FAIL mult_lo: got %h expected %h", lo, 32'hFFFF_FFF1); else n_pass++;

        do_op(OP_MULTU, 32'hFFFF_FFFD, 32'd5);
        wait_idle(cyc);
        n_checks++; if (cyc !== 2) $display("FAIL multu_busy_cycles: got %0d expected %0d", cyc, 2); else n_pass++;
        n_checks++; if (hi !== 32'h0000_0004) $display("FAIL multu_hi: got %h expected %h", hi, 32'h4); else n_pass++;
        n_checks++; if (lo !== 32'hFFFF_FFF1) $display("FAIL multu_lo: got %h expected %h", lo, 32'hFFFF_FFF1); else n_pass++;
    endtask

    task automatic test_div();
        do_op(OP_DIVU, 32'd100, 32'd7);
        wait_idle(cyc);
        n_checks++; if (cyc !== 33) $display("FAIL divu_busy_cycles: got %0d expected %0d", cyc, 33); else n_pass++;
        n_checks++; if (lo !== 32'd14) $display("FAIL divu_lo: got %h expected %h", lo, 32'd14); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL divu_hi: got %h expected %h", hi, 32'd2); else n_pass++;

        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_idle(cyc);
        n_checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_neg_lo: got %h expected %h", lo, 32'hFFFF_FFFD); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL div_neg_hi: got %h expected %h", hi, 32'hFFFF_FFFF); else n_pass++;

        do_op(OP_DIV, 32'd7, 32'hFFFF_FFFE);
        wait_idle(cyc);
        n_checks++; if (lo !== 32'hFFFF_FFFD) $display("FAIL div_negb_lo: got %h expected %h", lo, 32'hFFFF_FFFD); else n_pass++;
        n_checks++; if (hi !== 32'd1) $display("FAIL div_negb_hi: got %h expected %h", hi, 32'd1); else n_pass++;

        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_idle(cyc);
        n_checks++; if (lo !== 32'h8000_0000) $display("FAIL div_ovf_lo: got %h expected %h", lo, 32'h8000_0000); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL div_ovf_hi: got %h expected %h", hi, 32'd0); else n_pass++;
    endtask

    task automatic test_stall();
        // MFLO waiting behind a divide.
        @(negedge clk);
        op_valid = 1'b1; op = OP_DIV; src_a = 32'hFFFF_FF9C; src_b = 32'd7;
        @(negedge clk);
        op_valid = 1'b0; mf_req = 1'b1;
        #1;
        cyc = 0;
        while (stall_o === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk); #1;
        end
        n_checks++; if (cyc !== 33) $display("FAIL mf_stall_cycles: got %0d expected %0d", cyc, 33); else n_pass++;
        n_checks++; if (lo !== 32'hFFFF_FFF2) $display("FAIL mf_stall_lo: got %h expected %h", lo, 32'hFFFF_FFF2); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFE) $display("FAIL mf_stall_hi: got %h expected %h", hi, 32'hFFFF_FFFE); else n_pass++;
        mf_req = 1'b0;

        // MULT held back-to-back behind a divide.
        @(negedge clk);
        op_valid = 1'b1; op = OP_DIVU; src_a = 32'd50; src_b = 32'd6;
        @(negedge clk);
        op = OP_MULT; src_a = 32'd6; src_b = 32'd7;
        #1;
        cyc = 0;
        while (stall_o === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk); #1;
        end
        n_checks++; if (cyc !== 33) $display("FAIL b2b_stall_cycles: got %0d expected %0d", cyc, 33); else n_pass++;
        n_checks++; if (lo !== 32'd8) $display("FAIL b2b_div_lo: got %h expected %h", lo, 32'd8); else n_pass++;
        n_checks++; if (hi !== 32'd2) $display("FAIL b2b_div_hi: got %h expected %h", hi, 32'd2); else n_pass++;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        wait_idle(cyc);
        n_checks++; if (cyc !== 2) $display("FAIL b2b_mul_busy: got %0d expected %0d", cyc, 2); else n_pass++;
        n_checks++; if (lo !== 32'd42) $display("FAIL b2b_mul_lo: got %h expected %h", lo, 32'd42); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL b2b_mul_hi: got %h expected %h", hi, 32'd0); else n_pass++;
    endtask

    task automatic test_mthi_mtlo();
        do_op(OP_MTHI, 32'h1234_5678, 32'd0);
        n_checks++; if (hi !== 32'h1234_5678) $display("FAIL mthi_hi: got %h expected %h", hi, 32'h1234_5678); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL mthi_busy: got %b expected 0", busy); else n_pass++;
        do_op(OP_MTLO, 32'h0BAD_F00D, 32'd0);
        n_checks++; if (lo !== 32'h0BAD_F00D) $display("FAIL mtlo_lo: got %h expected %h", lo, 32'h0BAD_F00D); else n_pass++;
        do_op(3'b110, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        n_checks++; if (busy !== 1'b0) $display("FAIL badop_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (hi !== 32'h1234_5678) $display("FAIL badop_hi: got %h expected %h", hi, 32'h1234_5678); else n_pass++;
    endtask

    task automatic test_div_by_zero();
        @(negedge clk);
        op_valid = 1'b1; op = OP_DIVU; src_a = 32'd5; src_b = 32'd0;
        #1;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL dbz_at_t: got %b expected 0", div_by_zero); else n_pass++;
        @(negedge clk);
        op_valid = 1'b0;
        #1;
        n_checks++; if (div_by_zero !== 1'b1) $display("FAIL dbz_pulse: got %b expected 1", div_by_zero); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL dbz_busy: got %b expected 0", busy); else n_pass++;
        @(negedge clk); #1;
        n_checks++; if (div_by_zero !== 1'b0) $display("FAIL dbz_end: got %b expected 0", div_by_zero); else n_pass++;
        n_checks++; if (hi !== 32'h1234_5678) $display("FAIL dbz_hi: got %h expected %h", hi, 32'h1234_5678); else n_pass++;
        n_checks++; if (lo !== 32'h0BAD_F00D) $display("FAIL dbz_lo: got %h expected %h", lo, 32'h0BAD_F00D); else n_pass++;
    endtask

    task automatic test_flush();
        do_op(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        flush = 1'b1; mf_req = 1'b1;
        #1;
        n_checks++; if (stall_o !== 1'b0) $display("FAIL flush_stall: got %b expected 0", stall_o); else n_pass++;
        n_checks++; if (busy !== 1'b1) $display("FAIL flush_busy_t10: got %b expected 1", busy); else n_pass++;
        @(negedge clk);
        flush = 1'b0; mf_req = 1'b0;
        #1;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL flush_state: got %0d expected 0", state_dbg); else n_pass++;
        repeat (30) @(negedge clk);
        #1;
        n_checks++; if (hi !== 32'h1234_5678) $display("FAIL flush_hi: got %h expected %h", hi, 32'h1234_5678); else n_pass++;
        n_checks++; if (lo !== 32'h0BAD_F00D) $display("FAIL flush_lo: got %h expected %h", lo, 32'h0BAD_F00D); else n_pass++;

        @(negedge clk);
        op_valid = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF; flush = 1'b1;
        @(negedge clk);
        op_valid = 1'b0; flush = 1'b0;
        #1;
        n_checks++; if (hi !== 32'h1234_5678) $display("FAIL flush_idle_hi: got %h expected %h", hi, 32'h1234_5678); else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        do_op(OP_DIV, 32'd1000, 32'd3);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (hi !== 32'd0) $display("FAIL rstmid_hi: got %h expected %h", hi, 32'd0); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL rstmid_lo: got %h expected %h", lo, 32'd0); else n_pass++;
        n_checks++; if (state_dbg !== 2'd0) $display("FAIL rstmid_state: got %0d expected 0", state_dbg); else n_pass++;
    endtask

    task automatic test_early_out();
        int exp_cyc;
`ifdef MYCPU_DIV_EARLY_OUT_EN
        exp_cyc = 1;
`else
        exp_cyc = 33;
`endif
        do_op(OP_DIVU, 32'd3, 32'd10);
        wait_idle(cyc);
        n_checks++; if (cyc !== exp_cyc) $display("FAIL small_divu_busy: got %0d expected %0d", cyc, exp_cyc); else n_pass++;
        n_checks++; if (lo !== 32'd0) $display("FAIL small_divu_lo: got %h expected %h", lo, 32'd0); else n_pass++;
        n_checks++; if (hi !== 32'd3) $display("FAIL small_divu_hi: got %h expected %h", hi, 32'd3); else n_pass++;
        do_op(OP_DIV, 32'hFFFF_FFFD, 32'd10);
        wait_idle(cyc);
        n_checks++; if (lo !== 32'd0) $display("FAIL small_div_lo: got %h expected %h", lo, 32'd0); else n_pass++;
        n_checks++; if (hi !== 32'hFFFF_FFFD) $display("FAIL small_div_hi: got %h expected %h", hi, 32'hFFFF_FFFD); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_stall();
        test_mthi_mtlo();
        test_div_by_zero();
        test_flush();
        test_reset_mid_op();
        test_early_out();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
